// File: rtl/matrix_keyboard_pkg.sv
// Shared types and constants for the matrix keyboard scan controller:
// scan FSM states, key-code layout and the key index helper.
package matrix_keyboard_pkg;

   typedef enum logic [2:0] {
      IDLE,
      DRIVE,
      SAMPLE,
      COMPARE,
      EMIT
   } scan_state_e;

   localparam int KEY_CODE_W  = 8;
   localparam int RELEASE_BIT = 7;

   // Linear key index of the switch at (row, col) in a matrix with 'cols' columns.
   function automatic int unsigned key_index(input int unsigned row,
                                             input int unsigned col,
                                             input int unsigned cols);
      return row * cols + col;
   endfunction

endpackage

// File: rtl/matrix_keyboard_key_fifo.sv
// Small show-ahead FIFO for key codes. The head entry and its valid flag are
// registered, so a popped entry is replaced by the next one on the following
// cycle. A push into a full FIFO is accepted only when a pop happens in the
// same cycle; the caller detects dropped pushes from full_o/empty_o.
module matrix_keyboard_key_fifo import matrix_keyboard_pkg::*; #(
   parameter int DEPTH = 4,
   parameter int WIDTH = KEY_CODE_W,
   localparam int CW   = $clog2(DEPTH + 1)
) (
   input  logic             clk_i,
   input  logic             rst_n_i,
   input  logic             push_i,
   input  logic [WIDTH-1:0] push_data_i,
   input  logic             pop_i,
   output logic [WIDTH-1:0] head_o,
   output logic             head_valid_o,
   output logic [CW-1:0]    count_o,
   output logic             full_o,
   output logic             empty_o
);

   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]    count_q, count_d;
   logic [WIDTH-1:0] head_q, head_d;
   logic             valid_q, valid_d;
   logic             do_push, do_pop;

   function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
      if (p == AW'(DEPTH - 1)) return '0;
      return p + 1'b1;
   endfunction

   assign full_o  = (count_q == CW'(DEPTH));
   assign empty_o = (count_q == '0);
   assign do_pop  = pop_i && !empty_o;
   assign do_push = push_i && (!full_o || do_pop);

   // Pointer/count update and look-ahead of the next head entry (with bypass of
   // a push that lands directly in the head slot).
   always_comb begin
      wr_ptr_d = do_push ? ptr_inc(wr_ptr_q) : wr_ptr_q;
      rd_ptr_d = do_pop  ? ptr_inc(rd_ptr_q) : rd_ptr_q;
      count_d  = count_q;
      case ({do_push, do_pop})
         2'b10:   count_d = count_q + 1'b1;
         2'b01:   count_d = count_q - 1'b1;
         default: count_d = count_q;
      endcase
      valid_d = (count_d != '0);
      head_d  = '0;
      if (valid_d) begin
         if (do_push && (rd_ptr_d == wr_ptr_q)) head_d = push_data_i;
         else                                   head_d = mem_q[rd_ptr_d];
      end
   end

   // Storage array, written on accepted pushes only.
   always_ff @(posedge clk_i) begin
      if (do_push) mem_q[wr_ptr_q] <= push_data_i;
   end

   // Pointer, count and registered head state.
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         head_q   <= '0;
         valid_q  <= 1'b0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
         head_q   <= head_d;
         valid_q  <= valid_d;
      end
   end

   assign head_o       = head_q;
   assign head_valid_o = valid_q;
   assign count_o      = count_q;

endmodule

// File: rtl/matrix_keyboard_scan_ctrl.sv
// Row-scan, debounce and key-event controller for the matrix keyboard.
// Drives one row low at a time, samples the synchronised columns into a full
// matrix snapshot, debounces whole scans and pushes press codes into a FIFO.
// Optional feature: define MATRIX_KEYBOARD_RELEASE_EVT_EN to also push release
// codes (bit 7 set) after the presses of the same scan.
module matrix_keyboard_scan_ctrl import matrix_keyboard_pkg::*; #(
   parameter int ROWS           = 4,
   parameter int COLS           = 4,
   parameter int SCAN_DIV       = 50000,
   parameter int DEBOUNCE_SCANS = 3,
   parameter int FIFO_DEPTH     = 4,
   localparam int CNT_W         = $clog2(FIFO_DEPTH + 1)
) (
   input  logic                  ACLK,
   input  logic                  ARESETN,
   input  logic                  enable,
   output logic [ROWS-1:0]       row_n,
   input  logic [COLS-1:0]       col_n,
   output logic                  key_valid,
   output logic [KEY_CODE_W-1:0] key_code,
   input  logic                  key_pop,
   output logic [CNT_W-1:0]      fifo_count,
   output logic                  overflow,
   input  logic                  ovf_clr,
   output logic                  irq
);

   localparam int NK = ROWS * COLS;
   localparam int KW = (NK > 1) ? $clog2(NK) : 1;
   localparam int RW = (ROWS > 1) ? $clog2(ROWS) : 1;
   localparam int DW = $clog2(SCAN_DIV);
   localparam int SW = $clog2(DEBOUNCE_SCANS + 1);
`ifdef MATRIX_KEYBOARD_RELEASE_EVT_EN
   localparam int EW = 2 * NK;   // presses in the low half, releases in the high half
`else
   localparam int EW = NK;
`endif
   localparam int EIW = (EW > 1) ? $clog2(EW) : 1;

   scan_state_e state_q, state_d;
   logic [RW-1:0]   row_q, row_d;
   logic [DW-1:0]   dwell_q, dwell_d;
   logic [NK-1:0]   snap_q, snap_d;
   logic [NK-1:0]   prev_q, prev_d;
   logic [NK-1:0]   deb_q, deb_d;
   logic [SW-1:0]   stable_q, stable_d;
   logic [EW-1:0]   ev_q, ev_d;
   logic [ROWS-1:0] row_n_q, row_n_d;
   logic            ovf_q, ovf_d;
   logic [COLS-1:0] col_meta_q, col_sync_q, col;
   logic [EIW-1:0]  sel;
   logic [KEY_CODE_W-1:0] emit_code;
   logic            push, drop, fifo_full, fifo_empty;

   // Two-flop synchroniser for the asynchronous column returns (idle high).
   always_ff @(posedge ACLK or negedge ARESETN) begin
      if (!ARESETN) begin
         col_meta_q <= '1;
         col_sync_q <= '1;
      end else begin
         col_meta_q <= col_n;
         col_sync_q <= col_meta_q;
      end
   end

   assign col = ~col_sync_q;

   // Lowest pending event index; presses precede releases by bit position.
   always_comb begin
      sel = '0;
      for (int i = EW - 1; i >= 0; i--) begin
         if (ev_q[i]) sel = EIW'(i);
      end
   end

   // Key code for the selected event.
   always_comb begin
      emit_code = '0;
`ifdef MATRIX_KEYBOARD_RELEASE_EVT_EN
      if (int'(sel) < NK) begin
         emit_code[KW-1:0] = KW'(sel);
      end else begin
         emit_code[KW-1:0]      = KW'(int'(sel) - NK);
         emit_code[RELEASE_BIT] = 1'b1;
      end
`else
      emit_code[KW-1:0] = KW'(sel);
`endif
   end

   // Scan FSM: row sequencing, snapshot capture, debounce and event emission.
   always_comb begin
      state_d  = state_q;
      row_d    = row_q;
      dwell_d  = dwell_q;
      snap_d   = snap_q;
      prev_d   = prev_q;
      deb_d    = deb_q;
      stable_d = stable_q;
      ev_d     = ev_q;
      push     = 1'b0;
      case (state_q)
         IDLE: begin
            if (enable) begin
               state_d = DRIVE;
               row_d   = '0;
               dwell_d = DW'(SCAN_DIV - 1);
            end
         end
         DRIVE: begin
            if (dwell_q == '0) state_d = SAMPLE;
            else               dwell_d = dwell_q - 1'b1;
         end
         SAMPLE: begin
            snap_d[key_index(32'(row_q), 0, COLS) +: COLS] = col;
            if (row_q == RW'(ROWS - 1)) begin
               state_d = COMPARE;
            end else begin
               state_d = DRIVE;
               row_d   = row_q + 1'b1;
               dwell_d = DW'(SCAN_DIV - 1);
            end
         end
         COMPARE: begin
            if (snap_q != prev_q)                          stable_d = SW'(1);
            else if (stable_q < SW'(DEBOUNCE_SCANS))       stable_d = stable_q + 1'b1;
            prev_d = snap_q;
            ev_d   = '0;
            if (stable_d == SW'(DEBOUNCE_SCANS)) begin
               deb_d          = snap_q;
               ev_d[NK-1:0]   = snap_q & ~deb_q;
`ifdef MATRIX_KEYBOARD_RELEASE_EVT_EN
               ev_d[EW-1:NK]  = deb_q & ~snap_q;
`endif
            end
            state_d = EMIT;
         end
         EMIT: begin
            if (ev_q != '0) begin
               push      = 1'b1;
               ev_d[sel] = 1'b0;
            end
            if (ev_d == '0) begin
               state_d = DRIVE;
               row_d   = '0;
               dwell_d = DW'(SCAN_DIV - 1);
            end
         end
         default: state_d = IDLE;
      endcase
      // Disabling aborts the scan and forgets all matrix history.
      if (!enable) begin
         state_d  = IDLE;
         row_d    = '0;
         snap_d   = '0;
         prev_d   = '0;
         deb_d    = '0;
         stable_d = '0;
         ev_d     = '0;
         push     = 1'b0;
      end
   end

   // Row drive follows the next state so the pins change with the state register.
   always_comb begin
      row_n_d = '1;
      if (state_d == DRIVE) row_n_d[row_d] = 1'b0;
   end

   assign drop = push && fifo_full && !(key_pop && !fifo_empty);

   // Sticky overflow; a new drop wins over a clear in the same cycle.
   always_comb begin
      ovf_d = ovf_q;
      if (drop)         ovf_d = 1'b1;
      else if (ovf_clr) ovf_d = 1'b0;
   end

   // State registers.
   always_ff @(posedge ACLK or negedge ARESETN) begin
      if (!ARESETN) begin
         state_q  <= IDLE;
         row_q    <= '0;
         dwell_q  <= '0;
         snap_q   <= '0;
         prev_q   <= '0;
         deb_q    <= '0;
         stable_q <= '0;
         ev_q     <= '0;
         row_n_q  <= '1;
         ovf_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         row_q    <= row_d;
         dwell_q  <= dwell_d;
         snap_q   <= snap_d;
         prev_q   <= prev_d;
         deb_q    <= deb_d;
         stable_q <= stable_d;
         ev_q     <= ev_d;
         row_n_q  <= row_n_d;
         ovf_q    <= ovf_d;
      end
   end

   matrix_keyboard_key_fifo #(
      .DEPTH (FIFO_DEPTH),
      .WIDTH (KEY_CODE_W)
   ) u_fifo (
      .clk_i        (ACLK),
      .rst_n_i      (ARESETN),
      .push_i       (push),
      .push_data_i  (emit_code),
      .pop_i        (key_pop),
      .head_o       (key_code),
      .head_valid_o (key_valid),
      .count_o      (fifo_count),
      .full_o       (fifo_full),
      .empty_o      (fifo_empty)
   );

   assign row_n    = row_n_q;
   assign overflow = ovf_q;
   assign irq      = key_valid;

endmodule

// File: doc/matrix_keyboard_scan_ctrl.md
# matrix_keyboard_scan_ctrl

Scan controller for the 4×4 matrix keyboard peripheral. It sequences the row drives and samples the columns. It debounces the full key matrix and turns debounced press events into key codes in a small show-ahead FIFO. The AXI4-Lite register slice of the matrix_keyboard IP reads that FIFO and maps its status and interrupt.

## Interface
Parameters:
- ROWS, 4: number of matrix rows driven.
- COLS, 4: number of matrix columns sampled.
- SCAN_DIV, 50000: dwell cycles per row (≥2).
- DEBOUNCE_SCANS, 3: consecutive identical full scans required before the debounced matrix updates (≥1).
- FIFO_DEPTH, 4: key-code FIFO entries (power of two).

Ports:
- ACLK  in  1  single clock.
- ARESETN  in  1  reset; asynchronous, active-low.
- enable  in  1  scanning enable (from the control register).
- row_n  out  ROWS  row drives, active-low, at most one low at a time.
- col_n  in  COLS  column returns, active-low, asynchronous (pulled up off-chip).
- key_valid  out  1  FIFO non-empty.
- key_code  out  8  FIFO head: [KW-1:0] key index, where KW=$clog2(ROWS*COLS); [7] release flag (macro only); other bits 0.
- key_pop  in  1  pop the head; ignored when empty.
- fifo_count  out  $clog2(FIFO_DEPTH+1)  entries held.
- overflow  out  1  sticky; set when a push is dropped.
- ovf_clr  in  1  clears overflow.
- irq  out  1  level interrupt, equal to key_valid.

## Operation
- col_n passes through a 2-flop synchronizer and is inverted to give col (1 = pressed).
- FSM states and transitions:
  - IDLE: row_n = all 1. Leaves when enable=1, to DRIVE with r=0.
  - DRIVE: row_n[r]=0; the dwell counter runs SCAN_DIV-1 down to 0. Moves to SAMPLE when the counter reaches 0.
  - SAMPLE: snapshot[r] <= col. If r==ROWS-1, go to COMPARE; otherwise r++ and go to DRIVE.
  - COMPARE: debounce update (rules below), then go to EMIT.
  - EMIT: walk the event vector, pushing one code per cycle, lowest index first. When the vector is empty, go to DRIVE with r=0. EMIT lasts max(1, events) cycles.
- Debounce rules in COMPARE:
  - If snapshot ≠ prev: stable_cnt=1.
  - Otherwise: stable_cnt=min(stable_cnt+1, DEBOUNCE_SCANS).
  - prev <= snapshot.
  - When stable_cnt reaches DEBOUNCE_SCANS: debounced <= snapshot, and events = new & ~old (presses).
- Key index = r*COLS + c.
- enable=0 in any state: next state IDLE, and snapshot/prev/debounced/stable_cnt are cleared. FIFO and overflow are retained.
- FIFO behaviour:
  - Pushes come only from EMIT.
  - Full and no pop: the push is dropped and overflow is set.
  - Push and pop in the same cycle: both take effect (this includes the full case).
  - Pop while empty: no effect.
- ovf_clr and a new overflow in the same cycle: overflow stays 1 (set wins).

## Timing
- Reset values: row_n all 1, key_valid 0, key_code 0, fifo_count 0, overflow 0, irq 0; FSM in IDLE, r=0, all matrices 0.
- Full scan period = ROWS*(SCAN_DIV+1) + 1 + EMIT cycles.
- Synchronizer latency (2 cycles) is covered because SAMPLE follows ≥2 dwell cycles.
- Press latency: from the first scan that sees a stable key, the event is pushed in the EMIT of the DEBOUNCE_SCANS-th identical scan. key_valid rises the cycle after that push.
- key_code/key_valid are registered and show-ahead. After key_pop, the next head is visible on the next cycle.
- Enable rising: row 0 goes low on the cycle after IDLE is left.

## Configuration
- MATRIX_KEYBOARD_RELEASE_EVT_EN:
  - Defined: EMIT also pushes releases (old & ~new) with key_code[7]=1. Presses go before releases within one EMIT.
  - Undefined: press events only; key_code[7] is always 0.

## Structure
- Package matrix_keyboard_pkg holds:
  - the FSM state enum (IDLE, DRIVE, SAMPLE, COMPARE, EMIT);
  - KEY_CODE_W=8;
  - the RELEASE_BIT=7 constant;
  - a function for key index from row/column.
- One sub-module, matrix_keyboard_key_fifo: parameterised show-ahead FIFO with push, pop, count, full and empty.

## Test plan
All scenarios use SCAN_DIV=4, DEBOUNCE_SCANS=3.
- Reset with ARESETN low mid-DRIVE -> all outputs at reset values immediately; row_n=4'b1111.
- enable=1, no keys pressed -> row_n cycles 1110, 1101, 1011, 0111, each held 4 cycles; key_valid stays 0.
- Hold key at row 2, col 1 (col_n[1]=0 while row_n[2]=0) -> after the 3rd scan, key_code=0x09, key_valid=1, irq=1; key_pop -> key_valid=0.
- Bounce: toggle the key every scan for 5 scans -> no push, fifo_count=0.
- Press keys 0–5 together with no pops -> codes 0,1,2,3 in the FIFO, fifo_count=4, overflow=1; ovf_clr -> overflow=0.
- With the macro: press key 0x05 then release it -> FIFO holds 0x05 then 0x85. Without the macro -> 0x05 only.
- Deassert enable mid-scan -> next cycle IDLE, row_n=1111; FIFO contents unchanged.
